// File: rtl/stopwatch_time_counter.sv
// MM:SS up/down BCD stopwatch counter with idle/run/pause/done run control and prescaled tick.
// Build option SW_WRAP_EN: up count wraps 59:59 -> 00:00 and keeps running instead of stopping in DONE.
module stopwatch_time_counter #(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned TENS_MAX = 5
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       Op,
  input  logic       load,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_sec,
  output logic [3:0] sec_u,
  output logic [3:0] sec_t,
  output logic [3:0] min_u,
  output logic [3:0] min_t,
  output logic [3:0] Qmax,
  output logic [3:0] Qmin,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] UMAX = 4'd9;
  localparam logic [3:0] TMAX = 4'(TENS_MAX);
  localparam logic [3:0][3:0] MAXV = {TMAX, UMAX, TMAX, UMAX};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t            state_q, state_n;
  logic [PW-1:0]     presc_q, presc_n;
  logic [3:0][3:0]   dig_q, dig_n;
  logic [3:0][3:0]   up_dig, dn_dig, ld_dig;
  logic              carry_up, carry_dn;
  logic              all_max, all_zero;
  logic              up_hold, up_last, start_term;
  logic              running_n, done_n;

  // Digit index 0..3 = sec_u, sec_t, min_u, min_t; odd digits are tens.
  function automatic logic [3:0] dmax(input int k);
    dmax = ((k % 2) != 0) ? TMAX : UMAX;
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      Qmax[k] = (dig_q[k] == dmax(k));
      Qmin[k] = (dig_q[k] == 4'd0);
    end
  end

  assign all_max  = &Qmax;
  assign all_zero = &Qmin;

  // Ripple chain: a digit steps when every lower digit is at its wrap point.
  always_comb begin
    carry_up = 1'b1;
    carry_dn = 1'b1;
    up_dig   = dig_q;
    dn_dig   = dig_q;
    for (int k = 0; k < 4; k++) begin
      if (carry_up) up_dig[k] = Qmax[k] ? 4'd0 : dig_q[k] + 4'd1;
      if (carry_dn) dn_dig[k] = Qmin[k] ? dmax(k) : dig_q[k] - 4'd1;
      carry_up = carry_up & Qmax[k];
      carry_dn = carry_dn & Qmin[k];
    end
  end

  always_comb begin
    ld_dig[0] = (ld_sec[3:0] > UMAX) ? UMAX : ld_sec[3:0];
    ld_dig[1] = (ld_sec[7:4] > TMAX) ? TMAX : ld_sec[7:4];
    ld_dig[2] = (ld_min[3:0] > UMAX) ? UMAX : ld_min[3:0];
    ld_dig[3] = (ld_min[7:4] > TMAX) ? TMAX : ld_min[7:4];
  end

`ifdef SW_WRAP_EN
  assign up_hold = 1'b0;
  assign up_last = 1'b0;
`else
  assign up_hold = all_max;
  assign up_last = (up_dig == MAXV);
`endif

  assign start_term = Op ? up_hold : all_zero;

  // Next-state, prescaler and digit update; clear > load > stop > start.
  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    dig_n   = dig_q;
    if (clear) begin
      state_n = S_IDLE;
      presc_n = '0;
      dig_n   = '0;
    end else if (load && (state_q != S_RUN)) begin
      dig_n = ld_dig;
      if (state_q == S_DONE) state_n = S_IDLE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (stop) begin
            state_n = S_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_n = '0;
            if (Op) begin
              if (up_hold) begin
                state_n = S_DONE;
              end else begin
                dig_n = up_dig;
                if (up_last) state_n = S_DONE;
              end
            end else begin
              if (all_zero) begin
                state_n = S_DONE;
              end else begin
                dig_n = dn_dig;
                if (dn_dig == '0) state_n = S_DONE;
              end
            end
          end else begin
            presc_n = presc_q + PW'(1);
          end
        end
        S_IDLE, S_DONE: begin
          if (start) begin
            if (start_term) begin
              state_n = S_DONE;
            end else begin
              state_n = S_RUN;
              presc_n = '0;
            end
          end
        end
        S_PAUSE: begin
          if (start) state_n = start_term ? S_DONE : S_RUN;
        end
        default: state_n = S_IDLE;
      endcase
    end
    running_n = (state_n == S_RUN);
    done_n    = (state_n == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      dig_q   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      dig_q   <= dig_n;
      running <= running_n;
      done    <= done_n;
    end
  end

  assign sec_u = dig_q[0];
  assign sec_t = dig_q[1];
  assign min_u = dig_q[2];
  assign min_t = dig_q[3];

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed table-driven bench for stopwatch_time_counter with TICK_DIV=4.
module tb_stopwatch_time_counter;

  logic       CLK = 1'b0;
  logic       RSTn, start, stop, clear, Op, load;
  logic [7:0] ld_min, ld_sec;
  logic [3:0] sec_u, sec_t, min_u, min_t, Qmax, Qmin;
  logic       running, done;

  int checks = 0;
  int failures = 0;

  stopwatch_time_counter #(.TICK_DIV(4), .TENS_MAX(5)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .stop(stop), .clear(clear), .Op(Op),
    .load(load), .ld_min(ld_min), .ld_sec(ld_sec),
    .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u), .min_t(min_t),
    .Qmax(Qmax), .Qmin(Qmin), .running(running), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        cl, ld, st, sp, op;
    logic [7:0]  ldm, lds;
    int          n;
    logic [15:0] t;
    logic        r, d;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input logic cl, input logic ld, input logic st,
                              input logic sp, input logic op, input logic [7:0] ldm,
                              input logic [7:0] lds, input int n, input logic [15:0] t,
                              input logic r, input logic d);
    vec_t v;
    v.name = nm; v.cl = cl; v.ld = ld; v.st = st; v.sp = sp; v.op = op;
    v.ldm = ldm; v.lds = lds; v.n = n; v.t = t; v.r = r; v.d = d;
    vecs.push_back(v);
  endfunction

  function automatic logic [3:0] exp_max(input logic [15:0] t);
    return {t[15:12] == 4'd5, t[11:8] == 4'd9, t[7:4] == 4'd5, t[3:0] == 4'd9};
  endfunction

  function automatic logic [3:0] exp_min(input logic [15:0] t);
    return {t[15:12] == 4'd0, t[11:8] == 4'd0, t[7:4] == 4'd0, t[3:0] == 4'd0};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [15:0] t, input logic r, input logic d);
    chk({nm, ".time"}, {min_t, min_u, sec_t, sec_u}, t);
    chk({nm, ".running"}, 16'(running), 16'(r));
    chk({nm, ".done"}, 16'(done), 16'(d));
    chk({nm, ".Qmin"}, 16'(Qmin), 16'(exp_min(t)));
    chk({nm, ".Qmax"}, 16'(Qmax), 16'(exp_max(t)));
  endtask

  initial begin
    // name            cl ld st sp op ldm    lds    n   time      r  d
    add("load_0058",    0, 1, 0, 0, 1, 8'h00, 8'h58, 1, 16'h0058, 0, 0);
    add("start_up",     0, 0, 1, 0, 1, 8'h00, 8'h00, 4, 16'h0058, 1, 0);
    add("up_tick1",     0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 16'h0059, 1, 0);
    add("up_carry",     0, 0, 0, 0, 1, 8'h00, 8'h00, 4, 16'h0100, 1, 0);
    add("clear_run",    1, 0, 0, 0, 1, 8'h00, 8'h00, 1, 16'h0000, 0, 0);
    add("load_0002",    0, 1, 0, 0, 0, 8'h00, 8'h02, 1, 16'h0002, 0, 0);
    add("start_dn",     0, 0, 1, 0, 0, 8'h00, 8'h00, 4, 16'h0002, 1, 0);
    add("dn_tick1",     0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 16'h0001, 1, 0);
    add("dn_wait",      0, 0, 0, 0, 0, 8'h00, 8'h00, 3, 16'h0001, 1, 0);
    add("dn_zero",      0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 16'h0000, 0, 1);
    add("dn_done_end",  0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 16'h0000, 0, 0);
    add("clear_done",   1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 16'h0000, 0, 0);
    add("start_zero",   0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 16'h0000, 0, 1);
    add("zero_end",     0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 16'h0000, 0, 0);
    add("load_5959",    0, 1, 0, 0, 1, 8'h59, 8'h59, 1, 16'h5959, 0, 0);
`ifdef SW_WRAP_EN
    add("start_max",    0, 0, 1, 0, 1, 8'h00, 8'h00, 1, 16'h5959, 1, 0);
    add("max_tick",     0, 0, 0, 0, 1, 8'h00, 8'h00, 4, 16'h0000, 1, 0);
`else
    add("start_max",    0, 0, 1, 0, 1, 8'h00, 8'h00, 1, 16'h5959, 0, 1);
    add("max_hold",     0, 0, 0, 0, 1, 8'h00, 8'h00, 4, 16'h5959, 0, 0);
`endif
    add("clear_max",    1, 0, 0, 0, 1, 8'h00, 8'h00, 1, 16'h0000, 0, 0);
    add("load_0010",    0, 1, 0, 0, 1, 8'h00, 8'h10, 1, 16'h0010, 0, 0);
    add("start_p",      0, 0, 1, 0, 1, 8'h00, 8'h00, 3, 16'h0010, 1, 0);
    add("stop_p2",      0, 0, 0, 1, 1, 8'h00, 8'h00, 1, 16'h0010, 0, 0);
    add("paused",       0, 0, 0, 0, 1, 8'h00, 8'h00, 10, 16'h0010, 0, 0);
    add("resume",       0, 0, 1, 0, 1, 8'h00, 8'h00, 1, 16'h0010, 1, 0);
    add("resume_wait",  0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 16'h0010, 1, 0);
    add("resume_tick",  0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 16'h0011, 1, 0);
    add("clear_load",   1, 1, 0, 0, 1, 8'h12, 8'h34, 1, 16'h0000, 0, 0);
    add("load_0005",    0, 1, 0, 0, 1, 8'h00, 8'h05, 1, 16'h0005, 0, 0);
    add("start_5",      0, 0, 1, 0, 1, 8'h00, 8'h00, 2, 16'h0005, 1, 0);
    add("load_in_run",  0, 1, 0, 0, 1, 8'h33, 8'h33, 1, 16'h0005, 1, 0);
    add("run_tick",     0, 0, 0, 0, 1, 8'h00, 8'h00, 2, 16'h0006, 1, 0);
    add("clear_5",      1, 0, 0, 0, 1, 8'h00, 8'h00, 1, 16'h0000, 0, 0);
    add("clamp_sec",    0, 1, 0, 0, 1, 8'h00, 8'h7A, 1, 16'h0059, 0, 0);
    add("clamp_all",    0, 1, 0, 0, 1, 8'h68, 8'h3A, 1, 16'h5839, 0, 0);
    add("load_1000",    0, 1, 0, 0, 0, 8'h10, 8'h00, 1, 16'h1000, 0, 0);
    add("start_dn2",    0, 0, 1, 0, 0, 8'h00, 8'h00, 4, 16'h1000, 1, 0);
    add("borrow",       0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 16'h0959, 1, 0);
    add("op_flip",      0, 0, 0, 0, 1, 8'h00, 8'h00, 4, 16'h1000, 1, 0);
    add("stop_start",   0, 0, 1, 1, 1, 8'h00, 8'h00, 1, 16'h1000, 0, 0);
    add("stop_paused",  0, 0, 0, 1, 1, 8'h00, 8'h00, 3, 16'h1000, 0, 0);

    // Reset held two cycles with start asserted.
    RSTn = 1'b0; start = 1'b1; stop = 1'b0; clear = 1'b0; Op = 1'b1; load = 1'b0;
    ld_min = 8'h00; ld_sec = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.time", {min_t, min_u, sec_t, sec_u}, 16'h0000);
    chk("reset.Qmin", 16'(Qmin), 16'h000F);
    chk("reset.Qmax", 16'(Qmax), 16'h0000);
    chk("reset.running", 16'(running), 16'h0000);
    chk("reset.done", 16'(done), 16'h0000);
    RSTn = 1'b1; start = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      clear = v.cl; load = v.ld; start = v.st; stop = v.sp; Op = v.op;
      ld_min = v.ldm; ld_sec = v.lds;
      @(posedge CLK);
      #1;
      clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
      for (int c = 1; c < v.n; c++) begin
        @(posedge CLK);
        #1;
      end
      check_all(v.name, v.t, v.r, v.d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
